// File: rtl/spike_addr_if.sv
// Spike-address bus between the transmit block and the receiving MAC units.
interface spike_addr_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] source_address;
  logic                  addr_valid;
  logic                  addr_ready;
  logic                  clear;

  modport master (output source_address, addr_valid, clear, input addr_ready);
  modport slave  (input source_address, addr_valid, clear, output addr_ready);
endinterface

// File: rtl/spike_address_tx.sv
// Latches a neuron group's fire vector once per timestep, serializes the fired
// neurons' source addresses lowest index first, then pulses clear/done.
module spike_address_tx #(
  parameter int                    NUM_NEURONS  = 5,
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    BASE_ADDRESS = 3,
  parameter logic [ADDR_WIDTH-1:0] IDLE_ADDRESS = 12'hFFF
) (
  input  logic                   CLK_Tx,
  input  logic                   RST,
  input  logic [NUM_NEURONS-1:0] spikes_in,
  input  logic                   spikes_valid,
  spike_addr_if.master           tx,
  output logic                   done,
  output logic                   busy,
  output logic [NUM_NEURONS:0]   spike_count,
  output logic                   dropped
);

  typedef enum logic [1:0] {IDLE, SEND, CLEAR} state_e;

  localparam logic [NUM_NEURONS-1:0] PEND_ONE  = NUM_NEURONS'(1);
  localparam logic [NUM_NEURONS:0]   COUNT_ONE = (NUM_NEURONS + 1)'(1);

  state_e                  state_q, state_d;
  logic [NUM_NEURONS-1:0]  pending_q, pending_d;
  logic [NUM_NEURONS:0]    count_q, count_d;
  logic [NUM_NEURONS:0]    spike_count_q, spike_count_d;
  logic [ADDR_WIDTH-1:0]   source_address_q, source_address_d;
  logic                    addr_valid_q, addr_valid_d;
  logic                    clear_q, clear_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    dropped_q, dropped_d;
  logic [NUM_NEURONS-1:0]  remaining;

  // Address of the lowest set bit; the wrap past 2^ADDR_WIDTH is intentional.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [NUM_NEURONS-1:0] vec);
    logic [ADDR_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_WIDTH'(i);
    end
    return ADDR_WIDTH'(BASE_ADDRESS) + idx;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d          = state_q;
    pending_d        = pending_q;
    count_d          = count_q;
    spike_count_d    = spike_count_q;
    source_address_d = source_address_q;
    addr_valid_d     = addr_valid_q;
    clear_d          = 1'b0;
    done_d           = 1'b0;
    dropped_d        = spikes_valid && (state_q != IDLE);
    remaining        = pending_q & (pending_q - PEND_ONE);

    unique case (state_q)
      IDLE: begin
        if (spikes_valid) begin
          pending_d = spikes_in;
          count_d   = '0;
          if (|spikes_in) begin
            state_d          = SEND;
            addr_valid_d     = 1'b1;
            source_address_d = addr_of(spikes_in);
          end else begin
            state_d       = CLEAR;
            clear_d       = 1'b1;
            done_d        = 1'b1;
            spike_count_d = '0;
          end
        end
      end
      SEND: begin
        if (addr_valid_q && tx.addr_ready) begin
          pending_d = remaining;
          count_d   = count_q + COUNT_ONE;
          if (|remaining) begin
            source_address_d = addr_of(remaining);
          end else begin
            state_d          = CLEAR;
            addr_valid_d     = 1'b0;
            source_address_d = IDLE_ADDRESS;
            clear_d          = 1'b1;
            done_d           = 1'b1;
            spike_count_d    = count_q + COUNT_ONE;
          end
        end
      end
      CLEAR: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_Tx) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state_q          <= IDLE;
      pending_q        <= '0;
      count_q          <= '0;
      spike_count_q    <= '0;
      source_address_q <= IDLE_ADDRESS;
      addr_valid_q     <= 1'b0;
      clear_q          <= 1'b0;
      done_q           <= 1'b0;
      busy_q           <= 1'b0;
      dropped_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      pending_q        <= pending_d;
      count_q          <= count_d;
      spike_count_q    <= spike_count_d;
      source_address_q <= source_address_d;
      addr_valid_q     <= addr_valid_d;
      clear_q          <= clear_d;
      done_q           <= done_d;
      busy_q           <= busy_d;
      dropped_q        <= dropped_d;
    end
  end

  assign tx.source_address = source_address_q;
  assign tx.addr_valid     = addr_valid_q;
  assign tx.clear          = clear_q;
  assign done              = done_q;
  assign busy              = busy_q;
  assign spike_count       = spike_count_q;
  assign dropped           = dropped_q;

endmodule
